// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds predicted branches between fetch and execute,
// retires them in order, trains the predictor and raises a redirect on a
// mispredicted retire (flushing every younger entry).
// Optional feature macro: BRQ_STATS_EN (retire / mispredict counters).
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [63:0]      alloc_pc,
    input  logic [63:0]      alloc_pred_target,
    input  logic             alloc_pred_taken,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             resolve_valid,
    input  logic [TAG_W-1:0] resolve_tag,
    input  logic             resolve_taken,
    input  logic [63:0]      resolve_target,
    output logic             update_valid,
    output logic [63:0]      update_pc,
    output logic [63:0]      update_target,
    output logic             update_taken,
    output logic             mispredict,
    output logic [63:0]      redirect_pc,
    output logic [TAG_W:0]   count,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
);

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_RESOLVED = 2'd2
    } entry_state_e;

    entry_state_e     state_q [DEPTH];
    logic [63:0]      pc_q          [DEPTH];
    logic [63:0]      pred_target_q [DEPTH];
    logic             pred_taken_q  [DEPTH];
    logic [63:0]      res_target_q  [DEPTH];
    logic             res_taken_q   [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [TAG_W:0]   head_q, head_d;
    logic [TAG_W:0]   tail_q, tail_d;
    logic [TAG_W-1:0] head_idx, tail_idx;

    logic             full;
    logic             retire;
    logic             mis;
    logic             flush;
    logic             alloc_fire;
    logic             resolve_fire;

    logic [DEPTH-1:0] alloc_hit;
    logic [DEPTH-1:0] resolve_hit;
    logic [DEPTH-1:0] retire_hit;

    logic [63:0]      h_pc, h_pred_target, h_res_target;
    logic             h_pred_taken, h_res_taken;

    logic             update_valid_q;
    logic [63:0]      update_pc_q, update_target_q, redirect_pc_q;
    logic             update_taken_q;
    logic             mispredict_q;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];

    // Occupancy, handshake and head-entry decode.
    always_comb begin
        full          = (head_q[TAG_W] != tail_q[TAG_W]) && (head_idx == tail_idx);
        h_pc          = pc_q[head_idx];
        h_pred_target = pred_target_q[head_idx];
        h_pred_taken  = pred_taken_q[head_idx];
        h_res_target  = res_target_q[head_idx];
        h_res_taken   = res_taken_q[head_idx];
        retire        = (state_q[head_idx] == ST_RESOLVED);
        mis           = (h_res_taken != h_pred_taken) ||
                        (h_res_taken && h_pred_taken && (h_res_target != h_pred_target));
        flush         = retire && mis;
        // A flushing retire wins over anything arriving in the same cycle.
        alloc_fire    = alloc_valid && !full && !flush;
        resolve_fire  = resolve_valid && (state_q[resolve_tag] == ST_PENDING) && !flush;
    end

    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;
    assign count       = tail_q - head_q;

    // Per-entry one-hot strobes for allocation, resolution and retirement.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign alloc_hit[gi]   = alloc_fire   && (tail_idx    == TAG_W'(gi));
            assign resolve_hit[gi] = resolve_fire && (resolve_tag == TAG_W'(gi));
            assign retire_hit[gi]  = retire       && (head_idx    == TAG_W'(gi));
        end
    endgenerate

    // Pointer next-state: a flush collapses the queue to empty just past the retired entry.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (retire) begin
            head_d = head_q + (TAG_W+1)'(1);
        end
        if (flush) begin
            tail_d = head_q + (TAG_W+1)'(1);
        end else if (alloc_fire) begin
            tail_d = tail_q + (TAG_W+1)'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry lifecycle: FREE -> PENDING on alloc, -> RESOLVED on resolve, -> FREE on retire/flush.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst || flush) begin
                state_q[i] <= ST_FREE;
            end else if (retire_hit[i]) begin
                state_q[i] <= ST_FREE;
            end else if (alloc_hit[i]) begin
                state_q[i] <= ST_PENDING;
            end else if (resolve_hit[i]) begin
                state_q[i] <= ST_RESOLVED;
            end
        end
    end

    // Entry payload; only meaningful while the lifecycle state says so, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_hit[i]) begin
                pc_q[i]          <= alloc_pc;
                pred_target_q[i] <= alloc_pred_target;
                pred_taken_q[i]  <= alloc_pred_taken;
            end
            if (resolve_hit[i]) begin
                res_target_q[i]  <= resolve_target;
                res_taken_q[i]   <= resolve_taken;
            end
        end
    end

    // Registered training and redirect outputs; data fields hold between retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            update_valid_q  <= 1'b0;
            mispredict_q    <= 1'b0;
            update_pc_q     <= '0;
            update_target_q <= '0;
            update_taken_q  <= 1'b0;
            redirect_pc_q   <= '0;
        end else begin
            update_valid_q <= retire;
            mispredict_q   <= flush;
            if (retire) begin
                update_pc_q     <= h_pc;
                update_target_q <= h_res_target;
                update_taken_q  <= h_res_taken;
            end
            if (flush) begin
                redirect_pc_q <= h_res_taken ? h_res_target : (h_pc + 64'd4);
            end
        end
    end

    assign update_valid  = update_valid_q;
    assign update_pc     = update_pc_q;
    assign update_target = update_target_q;
    assign update_taken  = update_taken_q;
    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_pc_q;

`ifdef BRQ_STATS_EN
    logic [31:0] stat_branches_q, stat_mispredicts_q;

    // Saturating retire and mispredict counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (retire && (stat_branches_q != 32'hFFFF_FFFF)) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (flush && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH=8, TAG_W=3).
module tb_branch_resolve_queue;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [63:0] alloc_pc;
    logic [63:0] alloc_pred_target;
    logic        alloc_pred_taken;
    logic [2:0]  alloc_tag;
    logic        resolve_valid;
    logic [2:0]  resolve_tag;
    logic        resolve_taken;
    logic [63:0] resolve_target;
    logic        update_valid;
    logic [63:0] update_pc;
    logic [63:0] update_target;
    logic        update_taken;
    logic        mispredict;
    logic [63:0] redirect_pc;
    logic [3:0]  count;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef BRQ_STATS_EN
    localparam logic [31:0] EXP_BRANCHES = 32'd5;
    localparam logic [31:0] EXP_MISPRED  = 32'd2;
`else
    localparam logic [31:0] EXP_BRANCHES = 32'd0;
    localparam logic [31:0] EXP_MISPRED  = 32'd0;
`endif

    branch_resolve_queue #(.DEPTH(8), .TAG_W(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .alloc_valid       (alloc_valid),
        .alloc_ready       (alloc_ready),
        .alloc_pc          (alloc_pc),
        .alloc_pred_target (alloc_pred_target),
        .alloc_pred_taken  (alloc_pred_taken),
        .alloc_tag         (alloc_tag),
        .resolve_valid     (resolve_valid),
        .resolve_tag       (resolve_tag),
        .resolve_taken     (resolve_taken),
        .resolve_target    (resolve_target),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_target     (update_target),
        .update_taken      (update_taken),
        .mispredict        (mispredict),
        .redirect_pc       (redirect_pc),
        .count             (count),
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_alloc(input logic [63:0] pc, input logic pt, input logic [63:0] tgt);
        alloc_valid       = 1'b1;
        alloc_pc          = pc;
        alloc_pred_taken  = pt;
        alloc_pred_target = tgt;
        $display("[%0t] alloc  pc=0x%0h pred_taken=%0b pred_target=0x%0h", $time, pc, pt, tgt);
    endtask

    task automatic drive_resolve(input logic [2:0] tag, input logic t, input logic [63:0] tgt);
        resolve_valid  = 1'b1;
        resolve_tag    = tag;
        resolve_taken  = t;
        resolve_target = tgt;
        $display("[%0t] resolve tag=%0d taken=%0b target=0x%0h", $time, tag, t, tgt);
    endtask

    task automatic idle();
        alloc_valid   = 1'b0;
        resolve_valid = 1'b0;
    endtask

    // One branch through the whole queue: alloc, resolve, idle cycle, retire.
    task automatic single(input logic [63:0] pc, input logic pt, input logic [63:0] ptgt,
                          input logic rt, input logic [63:0] rtgt,
                          input logic exp_mis, input logic [63:0] exp_redir);
        logic [2:0] tag;
        tag = alloc_tag;
        drive_alloc(pc, pt, ptgt);
        step();
        idle();
        drive_resolve(tag, rt, rtgt);
        step();
        idle();
        step();
        check("single_update_valid", update_valid, 1);
        check("single_update_pc", update_pc, pc);
        check("single_mispredict", mispredict, exp_mis);
        if (exp_mis) check("single_redirect_pc", redirect_pc, exp_redir);
        step();
    endtask

    initial begin
        rst = 1'b1;
        alloc_valid = 1'b0; alloc_pc = '0; alloc_pred_target = '0; alloc_pred_taken = 1'b0;
        resolve_valid = 1'b0; resolve_tag = '0; resolve_taken = 1'b0; resolve_target = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_count", count, 0);
        check("rst_update_valid", update_valid, 0);
        check("rst_mispredict", mispredict, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_tag", alloc_tag, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_update_pc", update_pc, 0);

        // Correctly predicted not-taken branch, with the one idle cycle of latency
        check("p1_alloc_tag", alloc_tag, 0);
        drive_alloc(64'h1000, 1'b0, 64'h0);
        step();
        idle();
        check("p1_count", count, 1);
        drive_resolve(3'd0, 1'b0, 64'h0);
        step();
        idle();
        check("p1_idle_cycle", update_valid, 0);
        step();
        check("p1_update_valid", update_valid, 1);
        check("p1_update_pc", update_pc, 64'h1000);
        check("p1_update_taken", update_taken, 0);
        check("p1_mispredict", mispredict, 0);
        check("p1_count_after", count, 0);
        step();
        check("p1_pulse_drop", update_valid, 0);
        check("p1_pc_hold", update_pc, 64'h1000);

        // Predicted NT but taken: mispredict to the actual target
        check("p2_alloc_tag", alloc_tag, 1);
        drive_alloc(64'h2000, 1'b0, 64'h2004);
        step();
        idle();
        drive_resolve(3'd1, 1'b1, 64'h3000);
        step();
        idle();
        step();
        check("p2_mispredict", mispredict, 1);
        check("p2_redirect_pc", redirect_pc, 64'h3000);
        check("p2_update_target", update_target, 64'h3000);
        check("p2_update_taken", update_taken, 1);
        check("p2_count", count, 0);
        step();
        check("p2_mispredict_drop", mispredict, 0);

        // Out-of-order resolve; head mispredicts and flushes the resolved younger entry
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_alloc(64'h40, 1'b1, 64'h80);
        check("p3_tag0", alloc_tag, 0);
        step();
        drive_alloc(64'h50, 1'b0, 64'h0);
        check("p3_tag1", alloc_tag, 1);
        step();
        drive_alloc(64'h60, 1'b0, 64'h0);
        check("p3_tag2", alloc_tag, 2);
        step();
        idle();
        check("p3_count3", count, 3);
        drive_resolve(3'd2, 1'b0, 64'h64);
        step();
        check("p3_no_retire_tag2", update_valid, 0);
        drive_resolve(3'd0, 1'b0, 64'h0);
        step();
        check("p3_resolve_then_retire", update_valid, 0);
        // concurrent alloc and resolve on the flush edge must both be dropped
        drive_alloc(64'h999, 1'b0, 64'h0);
        drive_resolve(3'd1, 1'b0, 64'h0);
        step();
        idle();
        check("p3_mispredict", mispredict, 1);
        check("p3_redirect_pc", redirect_pc, 64'h44);
        check("p3_update_pc", update_pc, 64'h40);
        check("p3_count_flushed", count, 0);
        step();
        check("p3_tag2_gone", update_valid, 0);
        check("p3_mispredict_drop", mispredict, 0);
        step();
        check("p3_still_idle", update_valid, 0);
        check("p3_count_still0", count, 0);

        // Fill to DEPTH, overflow attempt, in-order drain and wrap
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("p4_fill_tag", alloc_tag, 64'(i));
            drive_alloc(64'h100 + 64'(i) * 64'h10, 1'b0, 64'h0);
            step();
        end
        idle();
        check("p4_full_count", count, 8);
        check("p4_full_ready", alloc_ready, 0);
        drive_alloc(64'hDEAD, 1'b0, 64'h0);
        step();
        idle();
        check("p4_overflow_count", count, 8);
        for (int i = 0; i < 8; i++) begin
            drive_resolve(3'(i), 1'b0, 64'h0);
            step();
            if (i == 0) begin
                check("p4_first_no_retire", update_valid, 0);
            end else begin
                check("p4_drain_valid", update_valid, 1);
                check("p4_drain_pc", update_pc, 64'h100 + 64'(i - 1) * 64'h10);
            end
        end
        idle();
        step();
        check("p4_last_valid", update_valid, 1);
        check("p4_last_pc", update_pc, 64'h170);
        check("p4_empty_count", count, 0);
        check("p4_wrap_tag", alloc_tag, 0);
        check("p4_ready_again", alloc_ready, 1);

        // Simultaneous allocate and retire: both happen, count unchanged
        drive_alloc(64'h500, 1'b0, 64'h0);
        step();
        idle();
        check("p5_count1", count, 1);
        drive_resolve(3'd0, 1'b0, 64'h0);
        step();
        idle();
        drive_alloc(64'h600, 1'b0, 64'h0);
        step();
        idle();
        check("p5_retire_valid", update_valid, 1);
        check("p5_retire_pc", update_pc, 64'h500);
        check("p5_count_same", count, 1);

        // Reset with 4 pending entries, concurrent alloc/resolve overridden
        for (int i = 0; i < 3; i++) begin
            drive_alloc(64'h610 + 64'(i) * 64'h10, 1'b0, 64'h0);
            step();
        end
        idle();
        check("p6_count4", count, 4);
        rst = 1'b1;
        drive_alloc(64'h700, 1'b0, 64'h0);
        drive_resolve(3'd1, 1'b0, 64'h0);
        step();
        rst = 1'b0;
        idle();
        check("p6_count0", count, 0);
        check("p6_update_valid", update_valid, 0);
        check("p6_update_pc", update_pc, 0);
        check("p6_alloc_tag", alloc_tag, 0);
        check("p6_stat_branches", stat_branches, 0);
        check("p6_stat_mispredicts", stat_mispredicts, 0);
        drive_resolve(3'd1, 1'b0, 64'h0);
        step();
        drive_resolve(3'd2, 1'b0, 64'h0);
        step();
        idle();
        step();
        check("p6_old_tags_ignored", update_valid, 0);
        check("p6_count_still0", count, 0);

        // Five retires, two of them mispredicted
        single(64'h700, 1'b0, 64'h704, 1'b0, 64'h704, 1'b0, 64'h0);
        single(64'h710, 1'b0, 64'h714, 1'b1, 64'h900, 1'b1, 64'h900);
        single(64'h720, 1'b1, 64'h800, 1'b1, 64'h800, 1'b0, 64'h0);
        single(64'h730, 1'b1, 64'h800, 1'b1, 64'h880, 1'b1, 64'h880);
        single(64'h740, 1'b0, 64'h0,   1'b0, 64'h744, 1'b0, 64'h0);
        check("p7_stat_branches", stat_branches, EXP_BRANCHES);
        check("p7_stat_mispredicts", stat_mispredicts, EXP_MISPRED);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
